// File: rtl/spi_responder.sv
// SPI mode-0 responder (target) with a one-byte transmit buffer.
// All SPI inputs are resynchronised into the clk domain.
// Edges are found by comparing the last synchroniser stage with one extra delay flop.
module spi_responder #(
  parameter logic [7:0] IDLE_BYTE   = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_underrun,
  output logic       frame_end,
  output logic       busy
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                 state_r, state_next_s;
  logic [SYNC_STAGES-1:0] cs_sync_r, sclk_sync_r, mosi_sync_r;
  logic                   cs_d_r, sclk_d_r;
  logic                   cs_s, sclk_s, mosi_s;
  logic                   cs_fall_s, cs_rise_s, sclk_rise_s, sclk_fall_s;

  logic [7:0] buf_r;          // transmit buffer; holds data while tx_ready_r is 0
  logic       tx_ready_r;
  logic [7:0] tx_shift_r, rx_shift_r, rx_data_r;
  logic [2:0] bit_cnt_r;
  logic       byte_done_r;    // set by the 8th rising edge, the next falling edge reloads
  logic       miso_r, rx_valid_r, tx_underrun_r, frame_end_r;

  logic       load_s, boundary_s, bypass_s, underrun_s, write_s;
  logic       tx_shift_en_s, rx_en_s, end_s, start_s;
  logic [7:0] load_byte_s;

  assign cs_s   = cs_sync_r[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_r[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_r[SYNC_STAGES-1];

  assign cs_fall_s   = cs_d_r & ~cs_s;
  assign cs_rise_s   = ~cs_d_r & cs_s;
  assign sclk_rise_s = ~sclk_d_r & sclk_s;
  assign sclk_fall_s = sclk_d_r & ~sclk_s;

  // Synchroniser chains and edge-detect delay flops, reset to the idle bus levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      cs_d_r      <= 1'b1;
      sclk_d_r    <= 1'b0;
    end else begin
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs};
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
      cs_d_r      <= cs_s;
      sclk_d_r    <= sclk_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state and per-cycle datapath controls; cs rising overrides any sclk edge.
  always_comb begin
    state_next_s  = state_r;
    start_s       = 1'b0;
    boundary_s    = 1'b0;
    tx_shift_en_s = 1'b0;
    rx_en_s       = 1'b0;
    end_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (cs_fall_s) begin
          state_next_s = ACTIVE;
          start_s      = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACTIVE: begin
        if (cs_rise_s) begin
          state_next_s = IDLE;
          end_s        = 1'b1;
        end else if (sclk_rise_s) begin
          rx_en_s = 1'b1;
        end else if (sclk_fall_s && byte_done_r) begin
          boundary_s = 1'b1;
        end else if (sclk_fall_s) begin
          tx_shift_en_s = 1'b1;
        end else begin
          state_next_s = ACTIVE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Transmit-byte selection: a same-cycle tx_valid into an empty buffer bypasses it.
  always_comb begin
    load_s      = start_s | boundary_s;
    bypass_s    = load_s & tx_valid & tx_ready_r;
    underrun_s  = boundary_s & tx_ready_r & ~tx_valid;
    write_s     = tx_valid & tx_ready_r & ~bypass_s;
    load_byte_s = IDLE_BYTE;
    if (bypass_s) begin
      load_byte_s = tx_data;
    end else if (!tx_ready_r) begin
      load_byte_s = buf_r;
    end else begin
      load_byte_s = IDLE_BYTE;
    end
  end

  // Datapath: buffer, shift registers, bit counter and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_r         <= 8'h00;
      tx_ready_r    <= 1'b1;
      tx_shift_r    <= 8'h00;
      rx_shift_r    <= 8'h00;
      rx_data_r     <= 8'h00;
      bit_cnt_r     <= 3'd0;
      byte_done_r   <= 1'b0;
      miso_r        <= 1'b1;
      rx_valid_r    <= 1'b0;
      tx_underrun_r <= 1'b0;
      frame_end_r   <= 1'b0;
    end else begin
      rx_valid_r    <= 1'b0;
      tx_underrun_r <= underrun_s;
      frame_end_r   <= end_s;

      if (load_s && !tx_ready_r) begin
        tx_ready_r <= 1'b1;
      end else if (write_s) begin
        buf_r      <= tx_data;
        tx_ready_r <= 1'b0;
      end

      if (load_s) begin
        tx_shift_r <= load_byte_s;
        miso_r     <= load_byte_s[7];
      end else if (tx_shift_en_s) begin
        tx_shift_r <= {tx_shift_r[6:0], 1'b0};
        miso_r     <= tx_shift_r[6];
      end else if (end_s) begin
        miso_r     <= 1'b1;
      end

      if (end_s || start_s) begin
        bit_cnt_r   <= 3'd0;
        rx_shift_r  <= 8'h00;
        byte_done_r <= 1'b0;
      end else if (boundary_s) begin
        byte_done_r <= 1'b0;
      end else if (rx_en_s) begin
        rx_shift_r <= {rx_shift_r[6:0], mosi_s};
        bit_cnt_r  <= bit_cnt_r + 3'd1;
        if (bit_cnt_r == 3'd7) begin
          rx_data_r   <= {rx_shift_r[6:0], mosi_s};
          rx_valid_r  <= 1'b1;
          byte_done_r <= 1'b1;
        end
      end
    end
  end

  assign miso        = miso_r;
  assign tx_ready    = tx_ready_r;
  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign tx_underrun = tx_underrun_r;
  assign frame_end   = frame_end_r;
  assign busy        = (state_r == ACTIVE);

endmodule

// File: tb/tb_spi_responder.sv
// Directed plus randomised bench for spi_responder with a byte-level reference model.
module tb_spi_responder;
  localparam int         SS = 2;
  localparam logic [7:0] IB = 8'hFF;

  logic       clk = 1'b0;
  logic       rst, cs, sclk, mosi, tx_valid;
  logic [7:0] tx_data;
  logic       miso, tx_ready, rx_valid, tx_underrun, frame_end, busy;
  logic [7:0] rx_data;

  int errors = 0;
  int checks = 0;
  int rxv_cnt = 0, und_cnt = 0, fe_cnt = 0;

  // Reference model state.
  logic       m_buf_v;
  logic [7:0] m_buf;
  logic [7:0] exp_rx_data;
  int         exp_rxv, exp_und, exp_fe;

  spi_responder #(.IDLE_BYTE(IB), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
    .frame_end(frame_end), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (rx_valid)    rxv_cnt++;
    if (tx_underrun) und_cnt++;
    if (frame_end)   fe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write(input logic [7:0] d);
    tx_valid = 1'b1;
    tx_data  = d;
    wait_n(1);
    tx_valid = 1'b0;
    if (!m_buf_v) begin
      m_buf_v = 1'b1;
      m_buf   = d;
    end
    check("tx_ready_after_write", tx_ready, 1'b0);
  endtask

  // nbits rising edges; byp_byte >= 0 puts byp_data on tx_valid in the boundary cycle
  // after that byte; rst_bit >= 0 pulses reset during that bit; m0 >= 0 fixes byte 0.
  task automatic frame(input int nbits, input int byp_byte, input logic [7:0] byp_data,
                       input int rst_bit, input int m0);
    logic [7:0] loads [0:8];
    logic [7:0] mb    [0:7];
    logic [7:0] got   [0:7];
    logic [7:0] mask;
    int nl, nb;
    nb = nbits / 8;
    nl = (rst_bit >= 0) ? 1 : 1 + nb;
    for (int k = 0; k < nl; k++) begin
      if (k > 0 && k - 1 == byp_byte && !m_buf_v) begin
        loads[k] = byp_data;
      end else if (m_buf_v) begin
        loads[k] = m_buf;
        m_buf_v  = 1'b0;
      end else begin
        loads[k] = IB;
        if (k > 0) exp_und++;
      end
    end
    for (int k = 0; k < 8; k++) begin
      mb[k]  = 8'($urandom);
      got[k] = 8'h00;
    end
    if (m0 >= 0) mb[0] = 8'(m0);

    cs   = 1'b0;
    mosi = mb[0][7];
    wait_n(4);
    check("busy_in_frame", busy, 1'b1);
    for (int i = 0; i < nbits; i++) begin
      got[i/8][7-(i%8)] = miso;
      sclk = 1'b1;
      if (i == rst_bit) begin
        wait_n(2);
        rst = 1'b1;
        #1;
        check("rst_miso", miso, 1'b1);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_pulses", {rx_valid, tx_underrun, frame_end}, 3'b000);
        cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        wait_n(3);
        rst = 1'b0;
        m_buf_v = 1'b0;
        exp_rx_data = 8'h00;
        wait_n(6);
        check("rst_no_frame_end", fe_cnt, exp_fe);
        check("rst_no_rx_valid", rxv_cnt, exp_rxv);
        check("rst_idle_miso", miso, 1'b1);
        return;
      end
      wait_n(4);
      sclk = 1'b0;
      if (i + 1 < nbits) mosi = mb[(i+1)/8][7-((i+1)%8)];
      if (i % 8 == 7 && i / 8 == byp_byte) begin
        wait_n(SS);
        tx_valid = 1'b1;
        tx_data  = byp_data;
        wait_n(1);
        tx_valid = 1'b0;
        check("bypass_tx_ready", tx_ready, 1'b1);
        wait_n(4 - SS - 1);
      end else begin
        wait_n(4);
      end
    end
    cs = 1'b1;
    wait_n(6);

    exp_rxv += nb;
    if (nb > 0) exp_rx_data = mb[nb-1];
    exp_fe++;
    for (int b = 0; b < nb; b++) check("miso_byte", got[b], loads[b]);
    if (nbits % 8 != 0) begin
      mask = 8'hFF << (8 - nbits % 8);
      check("miso_partial", got[nb] & mask, loads[nb] & mask);
    end
    check("rx_data", rx_data, exp_rx_data);
    check("rx_valid_count", rxv_cnt, exp_rxv);
    check("underrun_count", und_cnt, exp_und);
    check("frame_end_count", fe_cnt, exp_fe);
    check("busy_after", busy, 1'b0);
    check("miso_idle", miso, 1'b1);
    check("tx_ready_after", tx_ready, !m_buf_v);
  endtask

  initial begin
    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00;
    m_buf_v = 1'b0; m_buf = 8'h00; exp_rx_data = 8'h00;
    exp_rxv = 0; exp_und = 0; exp_fe = 0;
    wait_n(3);
    #1;
    check("reset_miso", miso, 1'b1);
    check("reset_tx_ready", tx_ready, 1'b1);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_busy", busy, 1'b0);
    check("reset_pulses", {rx_valid, tx_underrun, frame_end}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    wait_n(3);

    // Buffered byte out, fixed byte in.
    write(8'hA5);
    frame(8, -1, 8'h00, -1, 8'h3C);
    // Two bytes, nothing queued: idle byte twice.
    frame(16, -1, 8'h00, -1, -1);
    // Abort after 5 bits, then a clean frame.
    frame(5, -1, 8'h00, -1, -1);
    frame(8, -1, 8'h00, -1, -1);
    // Same-cycle write at the byte boundary bypasses the empty buffer.
    frame(16, 0, 8'h81, -1, -1);
    // Second write while the buffer is full is dropped.
    write(8'h11);
    write(8'h22);
    frame(16, -1, 8'h00, -1, -1);
    // Reset mid-frame, with a queued byte that reset must discard.
    write(8'h5A);
    frame(8, -1, 8'h00, 3, -1);
    frame(8, -1, 8'h00, -1, -1);

    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(1, 0) == 1) write(8'($urandom));
      frame(8 * $urandom_range(3, 1), -1, 8'h00, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
